// File: rtl/defs_isa_pkg.sv
// ---------------------------------------------------------------------------
// defs_isa: ISA definitions shared by the fetch unit and its neighbours.
//  - opcode constants (5-bit field at [OPC_MSB:OPC_LSB])
//  - fetch-unit FSM state encoding (WAIT / BUSCA / HALT)
//  - small helpers to pull the opcode out of a word and classify it
// ---------------------------------------------------------------------------
package defs_isa;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0] OP_DESVIO = 5'd12;
  localparam logic [4:0] OP_SALTO  = 5'd16;
  localparam logic [4:0] OP_FIM    = 5'd18;
  localparam logic [4:0] OP_JR     = 5'd27;

  // Fetch FSM encoding; 2'd3 is unused and recovers to WAIT.
  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_BUSCA = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Opcode field of an instruction word.
  function automatic logic [4:0] opcode_de(input logic [31:0] palavra);
    return palavra[OPC_MSB:OPC_LSB];
  endfunction

  // Opcodes that execute resolves into a redirect (branch or JR).
  function automatic logic e_redirecionamento(input logic [4:0] op);
    return (op == OP_DESVIO) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/busca_instrucao.sv
// ---------------------------------------------------------------------------
// busca_instrucao: instruction fetch unit, reading end of memoriaDeInstrucoes.
//  Owns the PC, presents it as the word address, captures the returned word
//  into the IR and hands it to decode over a valid/ready handshake.
//  Unconditional jumps are folded here (never reach decode), HALT stops
//  fetching, and execute may redirect with desvio/alvo_desvio.
// Ports:
//  clock          in   rising-edge clock, shared with the instruction memory
//  reset          in   asynchronous reset, active-low
//  endereco       out  word address to memory (= PC)
//  instrucao      in   memory word, combinational in the same cycle
//  instr_saida    out  IR contents to decode
//  pc_saida       out  address the IR word was fetched from
//  instr_valida   out  IR holds a valid word
//  instr_pronta   in   decode accepts the IR this cycle
//  desvio         in   taken branch / JR redirect pulse
//  alvo_desvio    in   redirect target
//  parado         out  unit is in HALT
//  contador_busca out  words delivered to decode (wraps)
// ---------------------------------------------------------------------------
module busca_instrucao
  import defs_isa::*;
#(
  parameter logic [31:0] PC_INICIAL   = 32'd1,
  parameter int unsigned ESPERA_CARGA = 2,
  parameter int unsigned LARGURA_END  = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  output logic [31:0] instr_saida,
  output logic [31:0] pc_saida,
  output logic        instr_valida,
  input  logic        instr_pronta,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic        parado,
  output logic [31:0] contador_busca
);

  localparam int unsigned W_ESPERA = (ESPERA_CARGA > 1) ? $clog2(ESPERA_CARGA) : 1;
  localparam logic [W_ESPERA-1:0] ESPERA_ULTIMO = W_ESPERA'(ESPERA_CARGA - 1);

  // The memory only decodes LARGURA_END bits; wider PCs alias on purpose,
  // so the parameter only needs to be a sane address width.
  if (LARGURA_END < 1 || LARGURA_END > 32 || ESPERA_CARGA < 1) begin : g_param_invalido
    $error("busca_instrucao: invalid LARGURA_END or ESPERA_CARGA");
  end

  logic [31:0]         pc_r, pc_s;
  logic [31:0]         ir_r, ir_s;
  logic [31:0]         pc_ir_r, pc_ir_s;
  logic [31:0]         contador_r, contador_s;
  logic                valida_r, valida_s;
  logic                parado_r, parado_s;
  logic [1:0]          estado_r, estado_s;
  logic [W_ESPERA-1:0] espera_r, espera_s;

  logic                transf_s;
  logic                ir_livre_s;
  logic [4:0]          op_s;

  assign transf_s   = valida_r & instr_pronta;
  assign ir_livre_s = ~valida_r | transf_s;
  assign op_s       = opcode_de(instrucao);

  // Next-state logic for PC, IR, handshake flags, FSM and delivery counter.
  always_comb begin
    pc_s     = pc_r;
    ir_s     = ir_r;
    pc_ir_s  = pc_ir_r;
    valida_s = valida_r;
    parado_s = parado_r;
    estado_s = estado_r;
    espera_s = espera_r;

    // A transfer counts even in the cycle a redirect flushes the IR.
    if (transf_s) begin
      contador_s = contador_r + 32'd1;
    end else begin
      contador_s = contador_r;
    end

    if (desvio && (estado_r != ST_WAIT)) begin
      // Redirect outranks everything, including a speculative HALT.
      pc_s     = alvo_desvio;
      valida_s = 1'b0;
      parado_s = 1'b0;
      estado_s = ST_BUSCA;
    end else begin
      case (estado_r)
        ST_WAIT: begin
          // A redirect arriving while memory initialises only moves the PC.
          if (desvio) begin
            pc_s = alvo_desvio;
          end else begin
            pc_s = pc_r;
          end
          if (transf_s) begin
            valida_s = 1'b0;
          end else begin
            valida_s = valida_r;
          end
          if (espera_r == ESPERA_ULTIMO) begin
            espera_s = '0;
            estado_s = ST_BUSCA;
          end else begin
            espera_s = espera_r + W_ESPERA'(1);
            estado_s = ST_WAIT;
          end
        end

        ST_BUSCA: begin
          if (ir_livre_s) begin
            case (op_s)
              OP_SALTO: begin
                // Folded jump: costs one fetch slot, IR drains or stays empty.
                pc_s     = {5'b0, instrucao[26:0]};
                valida_s = 1'b0;
              end
              OP_FIM: begin
                ir_s     = instrucao;
                pc_ir_s  = pc_r;
                valida_s = 1'b1;
                parado_s = 1'b1;
                estado_s = ST_HALT;
              end
              default: begin
                ir_s     = instrucao;
                pc_ir_s  = pc_r;
                valida_s = 1'b1;
                pc_s     = pc_r + 32'd1;
              end
            endcase
          end else begin
            // Stall: decode has not taken the IR yet, hold everything.
            pc_s     = pc_r;
            valida_s = valida_r;
          end
        end

        ST_HALT: begin
          // The HALT word itself may still drain to decode.
          if (transf_s) begin
            valida_s = 1'b0;
          end else begin
            valida_s = valida_r;
          end
        end

        default: begin
          valida_s = 1'b0;
          parado_s = 1'b0;
          espera_s = '0;
          estado_s = ST_WAIT;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r       <= PC_INICIAL;
      ir_r       <= 32'd0;
      pc_ir_r    <= 32'd0;
      valida_r   <= 1'b0;
      parado_r   <= 1'b0;
      contador_r <= 32'd0;
      estado_r   <= ST_WAIT;
      espera_r   <= '0;
    end else begin
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      pc_ir_r    <= pc_ir_s;
      valida_r   <= valida_s;
      parado_r   <= parado_s;
      contador_r <= contador_s;
      estado_r   <= estado_s;
      espera_r   <= espera_s;
    end
  end

  assign endereco       = pc_r;
  assign instr_saida    = ir_r;
  assign pc_saida       = pc_ir_r;
  assign instr_valida   = valida_r;
  assign parado         = parado_r;
  assign contador_busca = contador_r;

endmodule

// File: tb/tb_busca_instrucao.sv
// ---------------------------------------------------------------------------
// Testbench for busca_instrucao. A behavioural memory feeds the DUT; a
// reference model walks the program (jumps followed, HALT terminates) and
// queues the (pc, word) pairs decode should receive. A monitor pops and
// compares on every handshake, and checks stall/halt/flush invariants.
// ---------------------------------------------------------------------------
module tb_busca_instrucao;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic [31:0] instr_saida;
  logic [31:0] pc_saida;
  logic        instr_valida;
  logic        instr_pronta;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic        parado;
  logic [31:0] contador_busca;

  always #5 clock = ~clock;

  logic [31:0] mem [0:1023];
  assign instrucao = mem[endereco[9:0]];

  busca_instrucao dut (
    .clock          (clock),
    .reset          (reset),
    .endereco       (endereco),
    .instrucao      (instrucao),
    .instr_saida    (instr_saida),
    .pc_saida       (pc_saida),
    .instr_valida   (instr_valida),
    .instr_pronta   (instr_pronta),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
    .parado         (parado),
    .contador_busca (contador_busca)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    vectors++;
    if (atual !== esperado) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // ---------------- reference model: program walk ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] palavra;
  } entrega_t;

  entrega_t    exp_q[$];
  logic [31:0] walk_pc;
  bit          walk_fim;
  int          modelo_cont;

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    walk_pc  = pc;
    walk_fim = 1'b0;
  endtask

  // Follow the program from walk_pc: jumps (op 16) redirect silently,
  // HALT (op 18) is delivered and ends the stream, anything else is
  // delivered and the PC advances by one (mod 2^32).
  task automatic model_extend();
    int passos = 0;
    logic [31:0] w;
    while (!walk_fim && exp_q.size() < 8 && passos < 2048) begin
      w = mem[walk_pc[9:0]];
      passos++;
      if (w[31:27] == 5'd16) begin
        walk_pc = {5'b0, w[26:0]};
      end else begin
        exp_q.push_back('{pc: walk_pc, palavra: w});
        if (w[31:27] == 5'd18) walk_fim = 1'b1;
        else walk_pc = walk_pc + 32'd1;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          p_ok;
    logic        p_valida, p_pronta, p_desvio, p_parado;
    logic [31:0] p_end, p_ir, p_pcs, p_alvo;
    entrega_t    e;
    p_ok = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        p_ok = 1'b0;
      end else begin
        check("contador", contador_busca, modelo_cont);
        if (p_ok) begin
          if (p_valida && !p_pronta && !p_desvio) begin
            check("stall_ir", instr_saida, p_ir);
            check("stall_pc_saida", pc_saida, p_pcs);
            check("stall_valida", {31'd0, instr_valida}, 32'd1);
            check("stall_endereco", endereco, p_end);
          end
          if (p_parado && !p_desvio) check("halt_endereco", endereco, p_end);
          if (p_desvio) begin
            check("flush_valida", {31'd0, instr_valida}, 32'd0);
            check("flush_parado", {31'd0, parado}, 32'd0);
            check("flush_endereco", endereco, p_alvo);
          end
        end
        if (instr_valida && instr_saida[31:27] == 5'd18)
          check("parado_em_fim", {31'd0, parado}, 32'd1);
        if (instr_valida && instr_pronta) begin
          model_extend();
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL entrega_inesperada: got pc %h word %h expected none at %0t",
                     pc_saida, instr_saida, $time);
          end else begin
            e = exp_q.pop_front();
            check("entrega_palavra", instr_saida, e.palavra);
            check("entrega_pc", pc_saida, e.pc);
          end
          modelo_cont++;
        end
        if (desvio) model_restart(alvo_desvio);
        p_valida = instr_valida;  p_pronta = instr_pronta;
        p_desvio = desvio;        p_parado = parado;
        p_end    = endereco;      p_ir     = instr_saida;
        p_pcs    = pc_saida;      p_alvo   = alvo_desvio;
        p_ok     = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_on(input bit checar);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    if (checar) begin
      check("rst_valida", {31'd0, instr_valida}, 32'd0);
      check("rst_endereco", endereco, 32'd1);
      check("rst_contador", contador_busca, 32'd0);
      check("rst_parado", {31'd0, parado}, 32'd0);
      check("rst_pc_saida", pc_saida, 32'd0);
      check("rst_ir", instr_saida, 32'd0);
    end
    desvio = 1'b0;
    model_restart(32'd1);
    modelo_cont = 0;
  endtask

  task automatic reset_off(input bit checar_espera);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    if (checar_espera) begin
      check("espera_end0", endereco, 32'd1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("espera_end", endereco, 32'd1);
      end
      @(negedge clock);
      check("primeira_busca_end", endereco, 32'd2);
    end
  endtask

  task automatic wait_ir(input logic [31:0] pc, input int limite);
    bit achou = 1'b0;
    for (int i = 0; i < limite && !achou; i++) begin
      @(negedge clock);
      if (instr_valida && pc_saida == pc) achou = 1'b1;
    end
    vectors++;
    if (!achou) begin
      miscompares++;
      $display("FAIL timeout_ir: got no IR expected pc_saida %h", pc);
    end
  endtask

  task automatic wait_parado(input int limite);
    bit achou = 1'b0;
    for (int i = 0; i < limite && !achou; i++) begin
      @(negedge clock);
      if (parado) achou = 1'b1;
    end
    vectors++;
    if (!achou) begin
      miscompares++;
      $display("FAIL timeout_parado: got parado 0 expected 1");
    end
  endtask

  task automatic pulso_desvio(input logic [31:0] alvo);
    @(posedge clock);
    #1 desvio = 1'b1;
    alvo_desvio = alvo;
    @(posedge clock);
    #1 desvio = 1'b0;
  endtask

  task automatic programa_aleatorio();
    int r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       mem[i] = {5'd16, 27'($urandom_range(1, 1023))};
      else if (r < 11) mem[i] = {5'd18, 27'($urandom)};
      else begin
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd16 || op == 5'd18) op = 5'd1;
        mem[i] = {op, 27'($urandom)};
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    instr_pronta = 1'b1;
    desvio = 1'b0;
    alvo_desvio = 32'd0;
    modelo_cont = 0;
    model_restart(32'd1);

    for (int i = 0; i < 1024; i++) mem[i] = {5'd1, 27'(i)};
    mem[5]   = {5'd16, 27'd86};
    mem[17]  = {5'd12, 27'd5};
    mem[124] = {5'd18, 27'd0};

    // Reset state, WAIT length, first fetches.
    reset_on(1'b1);
    reset_off(1'b1);

    // Stall with IR = mem[3].
    wait_ir(32'd2, 20);
    @(posedge clock);
    #1 instr_pronta = 1'b0;
    repeat (4) @(posedge clock);
    #1 instr_pronta = 1'b1;

    // Jump at 5 to 86, run to HALT at 124.
    wait_parado(200);
    repeat (3) @(negedge clock);
    check("halt_end124", endereco, 32'd124);
    check("halt_parado", {31'd0, parado}, 32'd1);
    pulso_desvio(32'd110);
    wait_parado(100);

    // Deliver 17, then flush 18 with redirect to 84.
    pulso_desvio(32'd17);
    wait_ir(32'd17, 20);
    @(posedge clock);
    #1 instr_pronta = 1'b0;
    desvio = 1'b1;
    alvo_desvio = 32'd84;
    @(posedge clock);
    #1 desvio = 1'b0;
    instr_pronta = 1'b1;
    wait_parado(200);

    // Reset mid-stall with a valid IR.
    pulso_desvio(32'd40);
    @(posedge clock);
    #1 instr_pronta = 1'b0;
    repeat (3) @(posedge clock);
    reset_on(1'b1);
    instr_pronta = 1'b1;
    reset_off(1'b0);
    repeat (20) @(posedge clock);

    // Randomised programs, handshake and redirects.
    for (int p = 0; p < 3; p++) begin
      reset_on(1'b1);
      programa_aleatorio();
      reset_off(1'b0);
      for (int c = 0; c < 1500; c++) begin
        @(posedge clock);
        #1 instr_pronta = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 39) == 0) begin
          desvio = 1'b1;
          if ($urandom_range(0, 9) < 8) alvo_desvio = 32'($urandom_range(1, 1023));
          else                          alvo_desvio = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        end else begin
          desvio = 1'b0;
        end
        if (c == 700) begin
          reset_on(1'b1);
          reset_off(1'b0);
        end
      end
      #1 desvio = 1'b0;
    end

    repeat (5) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
